// File: rtl/pmodals_spi_reader.sv
// SPI master for the PmodALS light sensor: clocks out one 16-bit frame per
// start request and publishes frame[11:4] as the 8-bit light sample.
//
// state   | meaning
// S_IDLE  | CS and SCK high, waiting for start_pi
// S_SETUP | CS low, SCK high, CS-to-first-SCK setup time
// S_XFER  | 16 SCK periods, MISO sampled on each SCK rising edge
// S_QUIET | CS high, mandatory gap before the next conversion
module pmodals_spi_reader #(
  parameter int HALF_PERIOD = 50,
  parameter int CS_SETUP    = 10,
  parameter int QUIET       = 100
) (
  input  logic        clk_pi,
  input  logic        rst_n_pi,
  input  logic        start_pi,
  input  logic        miso_pi,
  output logic        cs_ctrl_po,
  output logic        sck_po,
  output logic        busy_po,
  output logic        valid_po,
  output logic [7:0]  dato_po,
  output logic [15:0] frame_po,
  output logic        err_po
);

  localparam int MAX_A = (HALF_PERIOD > CS_SETUP) ? HALF_PERIOD : CS_SETUP;
  localparam int MAX_V = (MAX_A > QUIET) ? MAX_A : QUIET;
  localparam int CW    = (MAX_V < 2) ? 1 : $clog2(MAX_V + 1);
  // IDLE is entered one edge before busy drops, so the quiet count is QUIET-1 cycles long
  localparam int QLOAD = (QUIET >= 2) ? QUIET - 2 : 0;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_XFER, S_QUIET} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] hcnt, hcnt_nxt;
  logic [3:0]    bit_cnt, bit_nxt;
  logic [15:0]   shreg, shreg_nxt;
  logic          cs_nxt, sck_nxt, valid_nxt, err_nxt;
  logic [7:0]    dato_nxt;
  logic [15:0]   frame_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hcnt_nxt  = hcnt;
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    cs_nxt    = cs_ctrl_po;
    sck_nxt   = sck_po;
    valid_nxt = 1'b0;
    dato_nxt  = dato_po;
    frame_nxt = frame_po;
    err_nxt   = err_po;
    case (state)
      S_IDLE: begin
        cs_nxt  = 1'b1;
        sck_nxt = 1'b1;
        if (start_pi) begin
          state_nxt = S_SETUP;
          cnt_nxt   = CW'(CS_SETUP);
        end
      end
      S_SETUP: begin
        cs_nxt = 1'b0;
        if (cnt == '0) begin
          state_nxt = S_XFER;
          sck_nxt   = 1'b0;
          hcnt_nxt  = CW'(HALF_PERIOD - 1);
          bit_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      S_XFER: begin
        if (hcnt != '0) begin
          hcnt_nxt = hcnt - CW'(1);
        end else if (!sck_po) begin
          sck_nxt   = 1'b1;
          shreg_nxt = {shreg[14:0], miso_pi};
          hcnt_nxt  = CW'(HALF_PERIOD - 1);
        end else if (bit_cnt == 4'd15) begin
          bit_nxt   = bit_cnt + 4'd1;
          cs_nxt    = 1'b1;
          valid_nxt = 1'b1;
          frame_nxt = shreg;
          dato_nxt  = shreg[11:4];
          err_nxt   = (|shreg[15:12]) | (|shreg[3:0]);
          state_nxt = (QUIET == 1) ? S_IDLE : S_QUIET;
          cnt_nxt   = CW'(QLOAD);
        end else begin
          sck_nxt  = 1'b0;
          bit_nxt  = bit_cnt + 4'd1;
          hcnt_nxt = CW'(HALF_PERIOD - 1);
        end
      end
      S_QUIET: begin
        if (cnt == '0) state_nxt = S_IDLE;
        else           cnt_nxt   = cnt - CW'(1);
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_pi or negedge rst_n_pi) begin
    if (!rst_n_pi) begin
      state      <= S_IDLE;
      cnt        <= '0;
      hcnt       <= '0;
      bit_cnt    <= 4'd0;
      shreg      <= 16'h0000;
      cs_ctrl_po <= 1'b1;
      sck_po     <= 1'b1;
      busy_po    <= 1'b0;
      valid_po   <= 1'b0;
      dato_po    <= 8'h00;
      frame_po   <= 16'h0000;
      err_po     <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      hcnt       <= hcnt_nxt;
      bit_cnt    <= bit_nxt;
      shreg      <= shreg_nxt;
      cs_ctrl_po <= cs_nxt;
      sck_po     <= sck_nxt;
      busy_po    <= (state != S_IDLE);
      valid_po   <= valid_nxt;
      dato_po    <= dato_nxt;
      frame_po   <= frame_nxt;
      err_po     <= err_nxt;
    end
  end

endmodule

// File: tb/tb_pmodals_spi_reader.sv
// Scoreboard bench for pmodals_spi_reader with a behavioural ADC081S021 model.
module tb_pmodals_spi_reader;
  localparam int HP  = 2;
  localparam int CSS = 2;
  localparam int QT  = 4;
  localparam int LAT = 1 + CSS + 32 * HP;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        miso = 1'b0;
  logic        cs_ctrl, sck, busy, valid, err;
  logic [7:0]  dato;
  logic [15:0] frame;

  pmodals_spi_reader #(.HALF_PERIOD(HP), .CS_SETUP(CSS), .QUIET(QT)) dut (
    .clk_pi(clk), .rst_n_pi(rst_n), .start_pi(start), .miso_pi(miso),
    .cs_ctrl_po(cs_ctrl), .sck_po(sck), .busy_po(busy), .valid_po(valid),
    .dato_po(dato), .frame_po(frame), .err_po(err));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  dato;
    logic [15:0] frame;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] sens_q[$];
  logic [15:0] sens_sr = 16'h0000;
  int checks = 0;
  int failures = 0;
  int rise_cnt = 0;
  int sck_edges = 0;
  int bad_edges = 0;
  int valid_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, expv);
    end
  endtask

  // Sensor: load a frame on CS falling, present the next bit on every SCK falling edge
  initial forever begin
    @(negedge cs_ctrl);
    sens_sr = (sens_q.size() != 0) ? sens_q.pop_front() : 16'h0000;
  end

  initial forever begin
    @(negedge sck);
    if (cs_ctrl == 1'b0) begin
      miso    = sens_sr[15];
      sens_sr = {sens_sr[14:0], 1'b0};
    end
  end

  // Monitor: SCK edge bookkeeping and scoreboard pop on every valid pulse
  initial begin
    logic prev_sck, prev_cs;
    exp_t e;
    prev_sck = 1'b1;
    prev_cs  = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (prev_cs && !cs_ctrl) rise_cnt = 0;
        if (sck !== prev_sck) begin
          sck_edges++;
          if (prev_cs && cs_ctrl) bad_edges++;
          if (!prev_sck && sck && !cs_ctrl) rise_cnt++;
        end
        if (valid) begin
          valid_cnt++;
          if (exp_q.size() == 0) begin
            check("valid_unexpected", {31'd0, valid}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("dato", {24'd0, dato}, {24'd0, e.dato});
            check("frame", {16'd0, frame}, {16'd0, e.frame});
            check("err", {31'd0, err}, {31'd0, e.err});
            check("sck_rises", rise_cnt, 16);
          end
        end
      end
      prev_sck = sck;
      prev_cs  = cs_ctrl;
    end
  end

  task automatic wait_idle(input string name);
    int m;
    m = 0;
    while (busy && m < 200) begin
      @(posedge clk); #1;
      m++;
    end
    check(name, {31'd0, busy}, 32'd0);
  endtask

  // One start pulse; optionally a stray start pulse around bit 5 of the frame
  task automatic do_frame(input logic [15:0] f, input logic [7:0] d, input logic e, input bit mid);
    int n, m;
    sens_q.push_back(f);
    exp_q.push_back('{dato: d, frame: f, err: e});
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    n = 0;
    for (int i = 1; i <= 500; i++) begin
      @(posedge clk); #1;
      if (mid && i == 24) start = 1'b1;
      if (mid && i == 25) start = 1'b0;
      if (valid) begin n = i; break; end
    end
    check("valid_latency", n, LAT);
    m = 0;
    while (busy && m < 200) begin
      @(posedge clk); #1;
      m++;
    end
    check("busy_fall_delay", m, QT);
  endtask

  initial begin
    int c, v0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_cs", {31'd0, cs_ctrl}, 32'd1);
    check("rst_sck", {31'd0, sck}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_dato", {24'd0, dato}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check("idle_sck_edges", sck_edges, 0);
    check("idle_cs", {31'd0, cs_ctrl}, 32'd1);

    do_frame(16'h0FF0, 8'hFF, 1'b0, 1'b0);
    do_frame(16'h0A50, 8'hA5, 1'b0, 1'b0);
    do_frame(16'h8FF1, 8'hFF, 1'b1, 1'b0);

    v0 = valid_cnt;
    do_frame(16'h0660, 8'h66, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    check("stray_start_cs", {31'd0, cs_ctrl}, 32'd1);
    check("stray_start_valids", valid_cnt - v0, 1);

    // Back-to-back conversions with start held high
    sens_q.push_back(16'h0120);
    sens_q.push_back(16'h0340);
    exp_q.push_back('{dato: 8'h12, frame: 16'h0120, err: 1'b0});
    exp_q.push_back('{dato: 8'h34, frame: 16'h0340, err: 1'b0});
    @(negedge clk); start = 1'b1;
    c = 0;
    while (!valid && c < 200) begin @(negedge clk); c++; end
    check("b2b_first_valid", {31'd0, valid}, 32'd1);
    c = 0;
    while (cs_ctrl && c < 50) begin c++; @(negedge clk); end
    start = 1'b0;
    check("b2b_cs_high_cycles", c, QT + 1);
    c = 0;
    while (!valid && c < 200) begin @(negedge clk); c++; end
    check("b2b_second_valid", {31'd0, valid}, 32'd1);
    @(posedge clk); #1;
    wait_idle("b2b_idle");

    // Reset during bit 8; the partial frame must vanish
    sens_q.push_back(16'hABCD);
    v0 = valid_cnt;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (35) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_cs", {31'd0, cs_ctrl}, 32'd1);
    check("abort_sck", {31'd0, sck}, 32'd1);
    check("abort_dato", {24'd0, dato}, 32'd0);
    check("abort_frame", {16'd0, frame}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    check("abort_valids", valid_cnt - v0, 0);
    rst_n = 1'b1;
    do_frame(16'h0C30, 8'hC3, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    check("pending_expects", exp_q.size(), 0);
    check("sck_edges_cs_high", bad_edges, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pmodals_spi_reader.md
# pmodals_spi_reader

SPI master that reads the PmodALS ambient light sensor (ADC081S021) and delivers the 8-bit light sample to the display path. It drives chip select and serial clock, shifts in a 16-bit frame from MISO and extracts bits [11:4] as the sample. It produces the sample word (`dato`) that feeds the 7-segment display formatter. It sits between the board PMOD pins and the display formatter.

## Interface

Parameters:
- `HALF_PERIOD`, 50: clk cycles per SCK half-period (≥1).
- `CS_SETUP`, 10: clk cycles from CS falling to first SCK falling edge (≥1).
- `QUIET`, 100: clk cycles CS held high after a frame before the next conversion may start (≥1).

Ports:
- `clk_pi`, input, 1: system clock; all logic is on its rising edge.
- `rst_n_pi`, input, 1: asynchronous active-low reset.
- `start_pi`, input, 1: conversion request, sampled only in IDLE.
- `miso_pi`, input, 1: serial data from the sensor.
- `cs_ctrl_po`, output, 1: chip select, active low.
- `sck_po`, output, 1: serial clock, idles high.
- `busy_po`, output, 1: high from the cycle after start is accepted until the end of QUIET.
- `valid_po`, output, 1: one-cycle pulse when `dato_po` is updated.
- `dato_po`, output, 8: last sample, equal to frame[11:4].
- `frame_po`, output, 16: last raw frame. Bit 15 is the first bit received.
- `err_po`, output, 1: last frame had a nonzero frame[15:12] or frame[3:0].

## Operation

- All outputs are registered.
- Reset values: `cs_ctrl_po`=1, `sck_po`=1, `busy_po`=0, `valid_po`=0, `dato_po`=0, `frame_po`=0, `err_po`=0. State is IDLE and all counters are 0.
- FSM states: IDLE → SETUP → XFER → QUIET → IDLE.
- IDLE:
  - CS and SCK are high.
  - If `start_pi`=1, go to SETUP. CS goes low and busy goes high on the next edge.
- SETUP:
  - CS is low and SCK is high for exactly `CS_SETUP` cycles.
  - Then go to XFER.
- XFER: 16 bits. Each bit is:
  - SCK low for `HALF_PERIOD` cycles, then SCK high for `HALF_PERIOD` cycles.
  - `miso_pi` is shifted in (MSB first) on the clk edge that drives SCK from 0 to 1.
  - A 4-bit bit counter and a half-period counter track the transfer. The bit counter wraps 15→0 at frame end.
- End of the 16th high phase:
  - CS goes high and the state goes to QUIET.
  - On the same edge: `frame_po` is loaded with the shift register, `dato_po` with its bits [11:4], and `err_po` is updated, and `valid_po` pulses for 1 cycle.
- QUIET:
  - CS and SCK are high for `QUIET` cycles.
  - Then go to IDLE and busy goes low.
- `start_pi` is ignored outside IDLE; requests are not queued.
- If `start_pi` is held high, conversions run back to back, separated by exactly `QUIET`+1 idle cycles of CS high.
- `mosi` is not driven; the sensor is read-only.

## Timing

- Start accepted at edge k → `cs_ctrl_po`=0 and `busy_po`=1 from edge k+1.
- First SCK falling edge at k+1+`CS_SETUP`.
- Sample of bit i (i=0..15) at edge k+1+`CS_SETUP`+(2i+1)·`HALF_PERIOD`.
- `valid_po` high and CS rising at edge k+1+`CS_SETUP`+32·`HALF_PERIOD`.
- `busy_po` low `QUIET` cycles after the `valid_po` edge.
- SCK:
  - Exactly 16 falling and 16 rising edges per frame.
  - No SCK edges while CS is high.
  - SCK is high at both CS transitions.
- Asynchronous reset mid-frame:
  - Outputs go to their reset values immediately.
  - The partial frame is discarded.
  - `dato_po` is cleared to 0 and does not hold its old value.
- Reset release: the first start may be accepted on the first clock edge after deassertion.

## Test plan

Benches use `HALF_PERIOD`=2, `CS_SETUP`=2, `QUIET`=4.

1. Reset check: hold `rst_n_pi`=0 → `cs_ctrl_po`=1, `sck_po`=1, `busy_po`=0, `dato_po`=0x00, `err_po`=0. Release and keep `start_pi`=0 for 50 cycles → no SCK edges.
2. Sensor model drives frame 0x0FF0 on SCK falling edges, one pulse on `start_pi` → exactly 1 `valid_po` pulse, at 67 cycles after start acceptance (1+2+64). `dato_po`=0xFF, `frame_po`=0x0FF0, `err_po`=0, 16 rising SCK edges counted.
3. Frame 0x0A50 → `dato_po`=0xA5, `err_po`=0. Then frame 0x8FF1 → `dato_po`=0xFF, `err_po`=1.
4. Pulse `start_pi` again at bit 5 of a running frame → ignored. Exactly 16 SCK periods and one `valid_po` pulse for the frame.
5. Hold `start_pi`=1 with frames 0x0120 then 0x0340 → `dato_po` 0x12 then 0x34. CS stays high for 5 cycles between the frames.
6. Assert `rst_n_pi` low during bit 8 → CS and SCK go high asynchronously, `dato_po`=0, no `valid_po` pulse. After release, a new start gives a correct frame.
